// File: rtl/ps2_host_ctl.sv
// PS/2 keyboard host: pad sync, RX deframer, and a command FSM covering init, LED updates, retry and bus arbitration.
// Define PS2HOST_TYPEMATIC_EN to append the typematic-rate command (0xF3, 0x20) to the init sequence.
module ps2_host_ctl #(
    parameter int INHIBIT_CYC  = 5000,
    parameter int TIMEOUT_CYC  = 1000000,
    parameter int FRAME_TO_CYC = 6000,
    parameter int RETRIES      = 3
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drv,
    output logic       ps2_dat_drv,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       busy,
    output logic       init_done,
    output logic       err,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_INH    = 3'd1,
        TX_BITS   = 3'd2,
        TX_LACK   = 3'd3,
        RESP_WAIT = 3'd4
    } state_t;

    localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYC - 1);
    localparam logic [31:0] INH_END    = 32'(INHIBIT_CYC);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_TO_CYC - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(RETRIES);
`ifdef PS2HOST_TYPEMATIC_EN
    localparam logic [1:0]  INIT_LAST  = 2'd2;
`else
    localparam logic [1:0]  INIT_LAST  = 2'd0;
`endif

    state_t      state;
    logic [1:0]  clk_sync, dat_sync;
    logic        clk_prev, clk_fall, dat_s;
    logic [3:0]  rx_cnt;
    logic [7:0]  rx_sr;
    logic        rx_par, rx_en, rx_ok;
    logic [31:0] rx_tmr;
    logic [31:0] cnt;
    logic [3:0]  tx_k;
    logic [7:0]  tx_byte;
    logic [7:0]  attempts;
    logic        led_seq, bat_wait, start_init, led_pend;
    logic [1:0]  step;
    logic        go_next, go_retry, go_abort, bat_enter, fwd;

    assign dbg_state = state;
    assign clk_fall  = clk_prev & ~clk_sync[1];
    assign dat_s     = dat_sync[1];
    assign rx_en     = (state == IDLE) || (state == RESP_WAIT);
    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign rx_ok     = rx_en && clk_fall && (rx_cnt == 4'd10) && dat_s && (^{rx_sr, rx_par});

    function automatic logic [7:0] step_byte(input logic is_led, input logic [1:0] idx,
                                             input logic [2:0] leds);
        if (is_led) return (idx == 2'd0) ? 8'hED : {5'b0, leds};
        case (idx)
            2'd1:    return 8'hF3;
            2'd2:    return 8'h20;
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    // Receive deframer; held cleared while the host owns the bus so partial frames are dropped.
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            rx_cnt <= 4'd0;
            rx_sr  <= 8'd0;
            rx_par <= 1'b0;
            rx_tmr <= 32'd0;
        end else if (!rx_en) begin
            rx_cnt <= 4'd0;
            rx_tmr <= 32'd0;
        end else if (clk_fall) begin
            rx_tmr <= 32'd0;
            if (rx_cnt == 4'd0) begin
                if (!dat_s) rx_cnt <= 4'd1;
            end else if (rx_cnt <= 4'd8) begin
                rx_sr  <= {dat_s, rx_sr[7:1]};
                rx_cnt <= rx_cnt + 4'd1;
            end else if (rx_cnt == 4'd9) begin
                rx_par <= dat_s;
                rx_cnt <= 4'd10;
            end else begin
                rx_cnt <= 4'd0;
            end
        end else if (rx_cnt != 4'd0) begin
            if (rx_tmr == FRAME_LAST) begin
                rx_cnt <= 4'd0;
                rx_tmr <= 32'd0;
            end else begin
                rx_tmr <= rx_tmr + 32'd1;
            end
        end
    end

    always_comb begin
        go_next   = 1'b0;
        go_retry  = 1'b0;
        go_abort  = 1'b0;
        bat_enter = 1'b0;
        fwd       = 1'b0;
        case (state)
            IDLE:    fwd = rx_ok;
            TX_BITS: go_retry = (cnt == TO_LAST);
            TX_LACK: go_retry = dat_s;
            RESP_WAIT: begin
                if (rx_ok) begin
                    if (bat_wait) begin
                        if (rx_sr == 8'hAA)      go_next  = 1'b1;
                        else if (rx_sr == 8'hFC) go_abort = 1'b1;
                        else if (rx_sr == 8'hFE) go_retry = 1'b1;
                        else                     fwd      = 1'b1;
                    end else if (rx_sr == 8'hFA) begin
                        if (!led_seq && step == 2'd0) bat_enter = 1'b1;
                        else                          go_next   = 1'b1;
                    end else if (rx_sr == 8'hFE) begin
                        go_retry = 1'b1;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (cnt == TO_LAST) begin
                    go_retry = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ps2_clk_drv <= 1'b0;
            ps2_dat_drv <= 1'b0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            err         <= 1'b0;
            rx_strobe   <= 1'b0;
            rx_byte     <= 8'd0;
            cnt         <= 32'd0;
            tx_k        <= 4'd0;
            tx_byte     <= 8'd0;
            attempts    <= 8'd0;
            led_seq     <= 1'b0;
            bat_wait    <= 1'b0;
            step        <= 2'd0;
            start_init  <= 1'b1;
            led_pend    <= 1'b0;
        end else begin
            rx_strobe <= fwd;
            if (fwd) rx_byte <= rx_sr;
            if (led_req && !err) led_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_init || (led_pend && init_done && !err)) begin
                        start_init  <= 1'b0;
                        led_pend    <= start_init ? led_pend : 1'b0;
                        led_seq     <= !start_init;
                        step        <= 2'd0;
                        busy        <= 1'b1;
                        tx_byte     <= start_init ? 8'hFF : 8'hED;
                        attempts    <= 8'd1;
                        cnt         <= 32'd0;
                        ps2_clk_drv <= 1'b1;
                        state       <= TX_INH;
                    end
                end
                TX_INH: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == INH_LAST) begin
                        ps2_dat_drv <= 1'b1;
                    end else if (cnt == INH_END) begin
                        ps2_clk_drv <= 1'b0;
                        cnt         <= 32'd0;
                        tx_k        <= 4'd0;
                        state       <= TX_BITS;
                    end
                end
                TX_BITS: begin
                    cnt <= cnt + 32'd1;
                    if (clk_fall) begin
                        tx_k <= tx_k + 4'd1;
                        if (tx_k < 4'd8)       ps2_dat_drv <= ~tx_byte[tx_k[2:0]];
                        else if (tx_k == 4'd8) ps2_dat_drv <= ^tx_byte;
                        else if (tx_k == 4'd9) ps2_dat_drv <= 1'b0;
                        else                   state       <= TX_LACK;
                    end
                end
                TX_LACK: begin
                    if (!dat_s) begin
                        state    <= RESP_WAIT;
                        cnt      <= 32'd0;
                        bat_wait <= 1'b0;
                    end
                end
                RESP_WAIT: begin
                    cnt <= cnt + 32'd1;
                    // BAT can take a while after the reset ack, so its wait gets a fresh window.
                    if (bat_enter) begin
                        bat_wait <= 1'b1;
                        cnt      <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (go_next) begin
                bat_wait <= 1'b0;
                if (step == (led_seq ? 2'd1 : INIT_LAST)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!led_seq) init_done <= 1'b1;
                end else begin
                    step        <= step + 2'd1;
                    tx_byte     <= step_byte(led_seq, step + 2'd1, led_val);
                    attempts    <= 8'd1;
                    cnt         <= 32'd0;
                    ps2_clk_drv <= 1'b1;
                    state       <= TX_INH;
                end
            end

            if (go_retry && attempts < RETRY_MAX) begin
                bat_wait    <= 1'b0;
                attempts    <= attempts + 8'd1;
                cnt         <= 32'd0;
                ps2_dat_drv <= 1'b0;
                ps2_clk_drv <= 1'b1;
                state       <= TX_INH;
            end

            if (go_abort || (go_retry && attempts >= RETRY_MAX)) begin
                err         <= 1'b1;
                busy        <= 1'b0;
                led_pend    <= 1'b0;
                bat_wait    <= 1'b0;
                ps2_clk_drv <= 1'b0;
                ps2_dat_drv <= 1'b0;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_ctl.sv
// Bench for ps2_host_ctl: behavioural keyboard on open-drain pads, byte scoreboards for both directions.
module tb_ps2_host_ctl;
    localparam int INH = 40;
    localparam int TO  = 2000;
    localparam int FTO = 200;
    localparam int RET = 3;

    logic       clk50m = 1'b0;
    logic       reset  = 1'b1;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_drv, ps2_dat_drv;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic       busy, init_done, err, rx_strobe;
    logic [7:0] rx_byte;
    logic [2:0] dbg_state;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];

    ps2_host_ctl #(
        .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FRAME_TO_CYC(FTO), .RETRIES(RET)
    ) dut (
        .clk50m(clk50m), .reset(reset),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_drv(ps2_clk_drv), .ps2_dat_drv(ps2_dat_drv),
        .led_req(led_req), .led_val(led_val),
        .busy(busy), .init_done(init_done), .err(err),
        .rx_strobe(rx_strobe), .rx_byte(rx_byte), .dbg_state(dbg_state)
    );

    assign ps2_clk_in = ~(ps2_clk_drv | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drv | dev_dat_low);

    always #10 clk50m = ~clk50m;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, %0d assertions, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50m);
    endtask

    task automatic pulse_led(input logic [2:0] v);
        led_val = v;
        led_req = 1'b1;
        cycles(1);
        led_req = 1'b0;
    endtask

    // Acts as the keyboard receiving one host command and acking it.
    task automatic dev_recv(input string tag);
        logic [9:0] bits;
        logic [7:0] exp_b;
        logic       exp_par;
        int         n;
        if (exp_tx_q.size() == 0) begin
            check({tag, "_queued"}, 32'(exp_tx_q.size()), 32'd1);
            exp_b = 8'h00;
        end else begin
            exp_b = exp_tx_q.pop_front();
        end
        exp_par = ~^exp_b;
        n = 0;
        while (!ps2_clk_drv && n < 6000) begin cycles(1); n++; end
        check({tag, "_inhibit"}, 32'(ps2_clk_drv), 32'd1);
        if (!ps2_clk_drv) return;
        n = 0;
        while (ps2_clk_drv && n < 1000) begin cycles(1); n++; end
        check({tag, "_start"}, 32'({ps2_clk_drv, ps2_dat_drv}), 32'd1);
        if (ps2_clk_drv) return;
        cycles(5);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            cycles(10);
            dev_clk_low = 1'b0;
            cycles(5);
            bits[i] = ps2_dat_in;
            cycles(5);
        end
        dev_dat_low = 1'b1;
        cycles(3);
        dev_clk_low = 1'b1;
        cycles(10);
        dev_clk_low = 1'b0;
        cycles(5);
        dev_dat_low = 1'b0;
        cycles(5);
        check({tag, "_byte"}, 32'(bits[7:0]), 32'(exp_b));
        check({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
        check({tag, "_stop"}, 32'(bits[9]), 32'd1);
    endtask

    task automatic dev_send(input logic [7:0] b, input logic bad_par);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_dat_low = ~fr[i];
            cycles(5);
            dev_clk_low = 1'b1;
            cycles(10);
            dev_clk_low = 1'b0;
            cycles(5);
        end
        dev_dat_low = 1'b0;
        cycles(10);
    endtask

    always @(negedge clk50m) begin
        if (!reset && rx_strobe) begin
            if (exp_rx_q.size() == 0) check("rx_spurious", 32'(rx_strobe), 32'd0);
            else                      check("rx_byte", 32'(rx_byte), 32'(exp_rx_q.pop_front()));
        end
    end

    initial begin
        int n;
        cycles(5);
        check("reset_clk_drv", 32'(ps2_clk_drv), 32'd0);
        check("reset_dat_drv", 32'(ps2_dat_drv), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_init_done", 32'(init_done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rx_strobe", 32'(rx_strobe), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        exp_tx_q.push_back(8'hFF);
        reset = 1'b0;
        cycles(2);
        check("init_busy", 32'(busy), 32'd1);
        dev_recv("init_ff");
        dev_send(8'hFA, 1'b0);
        dev_send(8'hAA, 1'b0);
`ifdef PS2HOST_TYPEMATIC_EN
        exp_tx_q.push_back(8'hF3);
        dev_recv("init_f3");
        dev_send(8'hFA, 1'b0);
        check("typematic_not_done", 32'(init_done), 32'd0);
        exp_tx_q.push_back(8'h20);
        dev_recv("init_rate");
        dev_send(8'hFA, 1'b0);
`endif
        cycles(5);
        check("init_done", 32'(init_done), 32'd1);
        check("init_busy_low", 32'(busy), 32'd0);
        check("init_err", 32'(err), 32'd0);

        // led_val changes after the request; the second byte must carry the later value.
        exp_tx_q.push_back(8'hED);
        exp_tx_q.push_back(8'h05);
        pulse_led(3'b010);
        cycles(2);
        check("led_busy", 32'(busy), 32'd1);
        led_val = 3'b101;
        dev_recv("led_ed");
        dev_send(8'hFA, 1'b0);
        check("led_busy_mid", 32'(busy), 32'd1);
        dev_recv("led_val");
        dev_send(8'hFA, 1'b0);
        cycles(5);
        check("led_busy_end", 32'(busy), 32'd0);
        check("led_err", 32'(err), 32'd0);

        for (int i = 0; i < 3; i++) exp_tx_q.push_back(8'hED);
        exp_tx_q.push_back(8'h03);
        pulse_led(3'b011);
        dev_recv("retry_ed1");
        dev_send(8'hFE, 1'b0);
        dev_recv("retry_ed2");
        dev_send(8'hFE, 1'b0);
        dev_recv("retry_ed3");
        dev_send(8'hFA, 1'b0);
        dev_recv("retry_val");
        exp_rx_q.push_back(8'h2A);
        dev_send(8'h2A, 1'b0);
        dev_send(8'hFA, 1'b0);
        cycles(5);
        check("retry_busy", 32'(busy), 32'd0);
        check("retry_err", 32'(err), 32'd0);

        exp_rx_q.push_back(8'h1C);
        dev_send(8'h1C, 1'b0);
        cycles(10);
        check("scan_consumed", 32'(exp_rx_q.size()), 32'd0);
        check("scan_hold", 32'(rx_byte), 32'h1C);
        dev_send(8'h1C, 1'b1);
        cycles(20);
        check("badpar_hold", 32'(rx_byte), 32'h1C);

        for (int i = 0; i < 3; i++) exp_tx_q.push_back(8'hED);
        pulse_led(3'b001);
        for (int i = 0; i < 3; i++) begin
            dev_recv("exhaust_ed");
            dev_send(8'hFE, 1'b0);
        end
        cycles(5);
        check("exhaust_err", 32'(err), 32'd1);
        check("exhaust_busy", 32'(busy), 32'd0);
        check("exhaust_init_done", 32'(init_done), 32'd1);
        pulse_led(3'b111);
        cycles(200);
        check("after_err_busy", 32'(busy), 32'd0);
        check("after_err_clk", 32'(ps2_clk_drv), 32'd0);

        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        n = 0;
        while (!ps2_clk_drv && n < 50) begin cycles(1); n++; end
        cycles(10);
        check("restart_inhibit", 32'(ps2_clk_drv), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_clk", 32'(ps2_clk_drv), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        cycles(3);

        for (int i = 0; i < 3; i++) exp_tx_q.push_back(8'hFF);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) dev_recv("timeout_ff");
        cycles(TO + 100);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_init_done", 32'(init_done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        pulse_led(3'b100);
        cycles(200);
        check("timeout_led_ignored", 32'(busy), 32'd0);
        check("timeout_led_clk", 32'(ps2_clk_drv), 32'd0);

        check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        check("rx_queue_empty", 32'(exp_rx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
